// File: rtl/spi_share_pkg.sv
// Shared types and constants for the two-client SPI pin-sharing controller.
package spi_share_pkg;
  localparam int CLIENT_W = 2;
  localparam int BYTE_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_TX,
    SHIFT,
    HOLD
  } state_e;

  // Index of the client that wins when both request in the same cycle.
  typedef logic rr_ptr_t;

  function automatic logic [CLIENT_W-1:0] client_onehot(input rr_ptr_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/spi_share_ctrl_if.sv
// Client handshake and SPI pin bundle for spi_share_ctrl.
interface spi_share_ctrl_if;
  import spi_share_pkg::*;

  // Handshake: client i's byte transfers on a clock edge where tx_valid[i] and
  // tx_ready[i] are both high; tx_data/tx_last must hold while tx_valid is high.
  // tx_ready only rises for the granted client; rx_valid is a 1-cycle pulse.
  logic [CLIENT_W-1:0]        req;
  logic [CLIENT_W-1:0]        gnt;
  logic [CLIENT_W-1:0]        tx_valid;
  logic [CLIENT_W*BYTE_W-1:0] tx_data;
  logic [CLIENT_W-1:0]        tx_last;
  logic [CLIENT_W-1:0]        tx_ready;
  logic [BYTE_W-1:0]          rx_data;
  logic [CLIENT_W-1:0]        rx_valid;
  logic                       busy;
  logic                       spi_SCLK;
  logic                       spi_MOSI;
  logic                       spi_MISO;
  logic                       spi_SS_n;
  state_e                     dbg_state;

  modport slave (
    input  req, tx_valid, tx_data, tx_last, spi_MISO,
    output gnt, tx_ready, rx_data, rx_valid, busy,
    output spi_SCLK, spi_MOSI, spi_SS_n, dbg_state
  );

  modport master (
    output req, tx_valid, tx_data, tx_last, spi_MISO,
    input  gnt, tx_ready, rx_data, rx_valid, busy,
    input  spi_SCLK, spi_MOSI, spi_SS_n, dbg_state
  );
endinterface

// File: rtl/spi_shift_engine.sv
// Mode-0 MSB-first byte shifter: SCLK divider, bit counter, MOSI drive, MISO sampling.
module spi_shift_engine
  import spi_share_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [BYTE_W-1:0] tx_byte_i,
  input  logic              miso_i,
  output logic              done_o,
  output logic [BYTE_W-1:0] rx_byte_o,
  output logic              sclk_o,
  output logic              mosi_o
);
  logic              active_q, active_d;
  logic [7:0]        div_q, div_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] tx_sh_q, tx_sh_d;
  logic [BYTE_W-1:0] rx_sh_q, rx_sh_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              tick;

  assign tick      = active_q && (div_q == 8'(CLK_DIV - 1));
  // Asserted in the last cycle before the eighth falling edge; rx_sh_q is complete.
  assign done_o    = tick && sclk_q && (bit_q == 3'd7);
  assign rx_byte_o = rx_sh_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    if (start_i) begin
      active_d = 1'b1;
      div_d    = '0;
      bit_d    = '0;
      tx_sh_d  = tx_byte_i;
      mosi_d   = tx_byte_i[BYTE_W-1];
      sclk_d   = 1'b0;
    end else if (active_q) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rx_sh_d = {rx_sh_q[BYTE_W-2:0], miso_i};
        end else if (bit_q == 3'd7) begin
          active_d = 1'b0;
          mosi_d   = 1'b0;
        end else begin
          bit_d   = bit_q + 3'd1;
          tx_sh_d = {tx_sh_q[BYTE_W-2:0], 1'b0};
          mosi_d  = tx_sh_q[BYTE_W-2];
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
    end
  end
endmodule

// File: rtl/spi_share_ctrl.sv
// Shares one SPI bus between two clients: round-robin arbitration, SS_n framing
// and byte handshakes; the bit-level work is done by spi_shift_engine.
module spi_share_ctrl
  import spi_share_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_HOLD  = 2
) (
  input logic             clk_clk,
  input logic             reset_reset,
  spi_share_ctrl_if.slave bus
);
  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [CLIENT_W-1:0] gnt_q, gnt_d;
  logic [CLIENT_W-1:0] rx_valid_q, rx_valid_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                ss_n_q, ss_n_d;
  logic                last_q, last_d;
  rr_ptr_t             rr_q, rr_d;
  rr_ptr_t             win;

  logic                sel, req_g, start, eng_done, sclk, mosi;
  logic [BYTE_W-1:0]   tx_byte, eng_rx;

  assign sel     = gnt_q[1];
  assign req_g   = |(bus.req & gnt_q);
  assign tx_byte = sel ? bus.tx_data[2*BYTE_W-1:BYTE_W] : bus.tx_data[BYTE_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ss_n_d     = ss_n_q;
    rr_d       = rr_q;
    last_d     = last_q;
    rx_valid_d = '0;
    rx_data_d  = rx_data_q;
    start      = 1'b0;
    win        = rr_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win     = (bus.req == 2'b11) ? rr_q : bus.req[1];
          gnt_d   = client_onehot(win);
          rr_d    = ~win;
          ss_n_d  = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 4'(SS_SETUP - 1)) state_d = WAIT_TX;
        else                           cnt_d   = cnt_q + 4'd1;
      end
      WAIT_TX: begin
        // A dropped request wins over a simultaneous byte offer.
        if (!req_g) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else if (|(bus.tx_valid & gnt_q)) begin
          start   = 1'b1;
          last_d  = bus.tx_last[sel];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (eng_done) begin
          rx_valid_d = gnt_q;
          rx_data_d  = eng_rx;
          cnt_d      = '0;
          state_d    = (last_q || !req_g) ? HOLD : WAIT_TX;
        end
      end
      HOLD: begin
        if (cnt_q == 4'(SS_HOLD - 1)) begin
          ss_n_d  = 1'b1;
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rx_valid_q <= '0;
      rx_data_q  <= '0;
      ss_n_q     <= 1'b1;
      last_q     <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      ss_n_q     <= ss_n_d;
      last_q     <= last_d;
      rr_q       <= rr_d;
    end
  end

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk_i     (clk_clk),
    .rst_i     (reset_reset),
    .start_i   (start),
    .tx_byte_i (tx_byte),
    .miso_i    (bus.spi_MISO),
    .done_o    (eng_done),
    .rx_byte_o (eng_rx),
    .sclk_o    (sclk),
    .mosi_o    (mosi)
  );

  assign bus.gnt       = gnt_q;
  assign bus.tx_ready  = (state_q == WAIT_TX && req_g) ? gnt_q : '0;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.spi_SCLK  = sclk;
  assign bus.spi_MOSI  = mosi;
  assign bus.spi_SS_n  = ss_n_q;
  assign bus.dbg_state = state_q;
endmodule
